// File: rtl/pattern_tx_if.sv
// Handshake/control bundle between a frame requester and the pattern_tx serial transmitter.
interface pattern_tx_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int GAP_W = 4
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [GAP_W-1:0] gap;
    logic             repeat_en;
    logic             abort;
    logic             serial_out;
    logic             valid_out;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, len, gap, repeat_en, abort,
        input  serial_out, valid_out, busy, done
    );

    modport slave (
        input  start, pattern, len, gap, repeat_en, abort,
        output serial_out, valid_out, busy, done
    );
endinterface

// File: rtl/pattern_tx.sv
// Serial bit-pattern transmitter with optional repetition and idle gap between frames.
// Define PATTERN_TX_PARITY_EN to append an even-parity bit to every frame.
module pattern_tx #(
    parameter int PAT_W     = 8,
    parameter int LEN_W     = 4,
    parameter int GAP_W     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic        clk,
    input logic        rst,
    pattern_tx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d, pat_in;
    logic [LEN_W-1:0] len_q, len_d, len_in;
    logic [LEN_W-1:0] cnt_q, cnt_d, last_idx;
    logic [GAP_W-1:0] gap_q, gap_d, gcnt_q, gcnt_d;
    logic             ser_q, ser_d, val_q, val_d;
    logic             busy_q, busy_d, done_q, done_d;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        if (l == '0 || l > LEN_W'(PAT_W)) return LEN_W'(PAT_W);
        return l;
    endfunction

    // Bits above len are zeroed at capture so the parity reduction sees only frame bits.
    function automatic logic [PAT_W-1:0] mask_pat(input logic [PAT_W-1:0] p,
                                                  input logic [LEN_W-1:0] l);
        logic [PAT_W-1:0] m;
        for (int i = 0; i < PAT_W; i++) m[i] = p[i] & (i < int'(l));
        return m;
    endfunction

    function automatic logic frame_bit(input logic [PAT_W-1:0] p,
                                       input logic [LEN_W-1:0] l,
                                       input logic [LEN_W-1:0] idx);
        logic [PAT_W-1:0] sh;
        logic [LEN_W-1:0] pos;
`ifdef PATTERN_TX_PARITY_EN
        if (idx == l) return ^p;
`endif
        pos = MSB_FIRST ? (l - LEN_W'(1) - idx) : idx;
        sh  = p >> pos;
        return sh[0];
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        gap_d    = gap_q;
        cnt_d    = cnt_q;
        gcnt_d   = gcnt_q;
        ser_d    = 1'b0;
        val_d    = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        len_in   = clamp_len(bus.len);
        pat_in   = mask_pat(bus.pattern, len_in);
`ifdef PATTERN_TX_PARITY_EN
        last_idx = len_q;
`else
        last_idx = len_q - LEN_W'(1);
`endif

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start && !bus.abort) begin
                    state_d = SHIFT;
                    pat_d   = pat_in;
                    len_d   = len_in;
                    gap_d   = bus.gap;
                    cnt_d   = '0;
                    gcnt_d  = '0;
                    ser_d   = frame_bit(pat_in, len_in, '0);
                    val_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q != last_idx) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    ser_d = frame_bit(pat_q, len_q, cnt_d);
                    val_d = 1'b1;
                end else if (bus.repeat_en && gap_q != '0) begin
                    state_d = GAP;
                    gcnt_d  = GAP_W'(1);
                end else if (bus.repeat_en) begin
                    cnt_d = '0;
                    ser_d = frame_bit(pat_q, len_q, '0);
                    val_d = 1'b1;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            GAP: begin
                if (gcnt_q == gap_q) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    ser_d   = frame_bit(pat_q, len_q, '0);
                    val_d   = 1'b1;
                end else begin
                    gcnt_d = gcnt_q + GAP_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort wins over everything once a frame is in flight.
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            ser_d   = 1'b0;
            val_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            ser_q   <= 1'b0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            ser_q   <= ser_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.serial_out = ser_q;
    assign bus.valid_out  = val_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx: queue-based frame model plus directed literal checks.
module tb_pattern_tx;
    localparam int PAT_W     = 8;
    localparam int LEN_W     = 4;
    localparam int GAP_W     = 4;
    localparam bit MSB_FIRST = 1'b1;
`ifdef PATTERN_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct packed {
        logic v;
        logic s;
        logic b;
        logic d;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    pattern_tx_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .GAP_W(GAP_W)) bus ();

    pattern_tx #(
        .PAT_W(PAT_W), .LEN_W(LEN_W), .GAP_W(GAP_W), .MSB_FIRST(MSB_FIRST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a queue of the output cycles still owed for the frame in flight.
    exp_t             q[$];
    exp_t             exp_cur;
    bit               m_active;
    bit               m_done;
    logic [PAT_W-1:0] m_pat;
    int               m_len;
    int               m_gap;
    logic [31:0]      sv;
    logic [31:0]      vv;

    function automatic exp_t mk(logic v, logic s, logic b, logic d);
        return exp_t'({v, s, b, d});
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push_frame();
        logic par = 1'b0;
        logic bi;
        for (int i = 0; i < m_len; i++) begin
            bi  = MSB_FIRST ? m_pat[m_len-1-i] : m_pat[i];
            par = par ^ bi;
            q.push_back(mk(1'b1, bi, 1'b1, 1'b0));
        end
        if (PB != 0) q.push_back(mk(1'b1, par, 1'b1, 1'b0));
    endtask

    task automatic model_reset();
        q.delete();
        m_active = 1'b0;
        m_done   = 1'b0;
        exp_cur  = '0;
    endtask

    task automatic model_step();
        if (m_done || (m_active && bus.abort)) begin
            model_reset();
        end else if (q.size() > 0) begin
            exp_cur = q.pop_front();
        end else if (m_active) begin
            if (bus.repeat_en) begin
                for (int i = 0; i < m_gap; i++) q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
                push_frame();
                exp_cur = q.pop_front();
            end else begin
                exp_cur = mk(1'b0, 1'b0, 1'b0, 1'b1);
                m_done  = 1'b1;
            end
        end else if (bus.start && !bus.abort) begin
            m_len    = (bus.len == 0 || int'(bus.len) > PAT_W) ? PAT_W : int'(bus.len);
            m_pat    = bus.pattern;
            m_gap    = int'(bus.gap);
            m_active = 1'b1;
            push_frame();
            exp_cur = q.pop_front();
        end else begin
            exp_cur = '0;
        end
    endtask

    // One clock: model advances on the edge, DUT is compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("serial_out", 32'(bus.serial_out), 32'(exp_cur.s));
        check("valid_out",  32'(bus.valid_out),  32'(exp_cur.v));
        check("busy",       32'(bus.busy),       32'(exp_cur.b));
        check("done",       32'(bus.done),       32'(exp_cur.d));
        sv = {sv[30:0], bus.serial_out};
        vv = {vv[30:0], bus.valid_out};
    endtask

    task automatic drive(logic st, logic [7:0] p, logic [3:0] l, logic [3:0] g, logic r);
        bus.start     = st;
        bus.pattern   = p;
        bus.len       = l;
        bus.gap       = g;
        bus.repeat_en = r;
        bus.abort     = 1'b0;
    endtask

    initial begin
        int f;
        n_checks = 0;
        n_err    = 0;
        sv       = '0;
        vv       = '0;
        model_reset();
        rst = 1'b1;
        drive(1'b0, 8'h00, 4'd0, 4'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset serial_out", 32'(bus.serial_out), 0);
        check("reset valid_out",  32'(bus.valid_out),  0);
        check("reset busy",       32'(bus.busy),       0);
        check("reset done",       32'(bus.done),       0);
        rst = 1'b0;
        tick();

        // Single full frame, MSB first.
        drive(1'b1, 8'b1011_0010, 4'd8, 4'd0, 1'b0);
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        check("frame B2 bits",  sv[7:0], 8'hB2);
        check("frame B2 valid", vv[7:0], 8'hFF);
        repeat (PB) tick();
        tick();
        check("frame B2 done", 32'(bus.done), 1);
        check("frame B2 busy", 32'(bus.busy), 0);
        tick();

        // Short frame and clamping of len=0.
        drive(1'b1, 8'hA5, 4'd3, 4'd0, 1'b0);
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        check("len3 bits", sv[2:0], 3'b101);
        repeat (PB) tick();
        tick();
        check("len3 done", 32'(bus.done), 1);
        tick();
        drive(1'b1, 8'hA5, 4'd0, 4'd0, 1'b0);
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        check("len0 bits", sv[7:0], 8'hA5);
        repeat (PB + 1) tick();
        check("len0 done", 32'(bus.done), 1);
        tick();

        // Repeat with gap=2, repeat_en dropped during the second frame.
        f = 4 + PB;
        drive(1'b1, 8'hF0, 4'd4, 4'd2, 1'b1);
        tick();
        bus.start = 1'b0;
        repeat (f + 2) tick();
        bus.repeat_en = 1'b0;
        repeat (f - 1) tick();
        check("gap2 valid", vv & ((32'd1 << (2*f + 2)) - 1),
              (((32'd1 << f) - 1) << (f + 2)) | ((32'd1 << f) - 1));
        tick();
        check("gap2 done", 32'(bus.done), 1);
        tick();

        // Back-to-back with gap=0.
        drive(1'b1, 8'hF0, 4'd4, 4'd0, 1'b1);
        tick();
        bus.start = 1'b0;
        repeat (f) tick();
        bus.repeat_en = 1'b0;
        repeat (f - 1) tick();
        check("gap0 valid", vv & ((32'd1 << (2*f)) - 1), (32'd1 << (2*f)) - 1);
        tick();
        check("gap0 done", 32'(bus.done), 1);
        tick();

        // Start while busy is ignored; abort returns to idle without done.
        drive(1'b1, 8'b1011_0010, 4'd8, 4'd0, 1'b0);
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (2) tick();
        check("abort prefix bits", sv[4:0], 5'b10110);
        bus.abort = 1'b1;
        tick();
        check("abort valid", 32'(bus.valid_out), 0);
        check("abort busy",  32'(bus.busy),      0);
        bus.abort = 1'b0;
        repeat (3) begin
            tick();
            check("abort no done", 32'(bus.done), 0);
        end

`ifdef PATTERN_TX_PARITY_EN
        drive(1'b1, 8'b0000_0111, 4'd3, 4'd0, 1'b0);
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        check("parity bits",  sv[3:0], 4'b1111);
        check("parity valid", vv[3:0], 4'b1111);
        tick();
        check("parity done", 32'(bus.done), 1);
        tick();
`endif

        // Async reset during the 4th bit of an 8-bit frame.
        drive(1'b1, 8'b1011_0010, 4'd8, 4'd0, 1'b1);
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("rst serial_out", 32'(bus.serial_out), 0);
        check("rst valid_out",  32'(bus.valid_out),  0);
        check("rst busy",       32'(bus.busy),       0);
        check("rst done",       32'(bus.done),       0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) tick();
        check("post-rst quiet", vv[3:0], 4'b0000);

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            bus.start     = ($urandom_range(0, 7) == 0);
            bus.pattern   = 8'($urandom);
            bus.len       = 4'($urandom_range(0, 15));
            bus.gap       = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 3));
            bus.repeat_en = ($urandom_range(0, 1) == 1);
            bus.abort     = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/pattern_tx.md
Name: pattern_tx

Overview:
- Serial bit-pattern transmitter: takes a parallel pattern and shifts it out one bit per clock with a valid strobe.
- Optional repetition with a programmable idle gap between frames.
- Acts as the driving end for the team's serial sequence-detector FSMs.
- Used on-chip as a built-in stimulus source and in benches as a frame generator toward the detector inputs.

Parameters:
- PAT_W, 8, pattern register width in bits (max frame length).
- LEN_W, 4, width of len input; must satisfy 2^LEN_W > PAT_W.
- GAP_W, 4, width of gap counter/input.
- MSB_FIRST, 1, 1 = bit len-1 transmitted first, 0 = bit 0 first.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a frame; sampled only in IDLE.
- pattern  input  PAT_W  frame data; low len bits used.
- len  input  LEN_W  bits per frame; 0 or >PAT_W clamps to PAT_W.
- gap  input  GAP_W  idle cycles between repeated frames.
- repeat_en  input  1  live-sampled at end of each frame; 1 = send again.
- abort  input  1  synchronous cancel of any activity.
- serial_out  output  1  transmitted bit; 0 when not valid.
- valid_out  output  1  high on every cycle carrying a frame bit.
- busy  output  1  high from cycle after accepted start until done.
- done  output  1  one-cycle pulse after final frame.

Behaviour:
- One clock domain: clk. Reset rst is asynchronous and active-high.
- Reset: state IDLE; serial_out=0, valid_out=0, busy=0, done=0; all counters and capture registers 0.
- All outputs are registered. No combinational input-to-output paths.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - start=1 at edge k captures pattern, clamped len, and gap.
  - State goes to SHIFT; busy=1 from edge k.
  - The first bit is on serial_out with valid_out=1 in the cycle following edge k (1-cycle latency).
- SHIFT:
  - Bits are emitted on len consecutive cycles; bit counter runs 0..len-1.
  - MSB_FIRST=1 order: pattern[len-1] down to pattern[0]. MSB_FIRST=0 order: pattern[0] up to pattern[len-1].
  - After the last bit, repeat_en is sampled:
    - 1 and gap>0: go to GAP.
    - 1 and gap=0: the next frame starts back-to-back in the following cycle from the same captured pattern.
    - 0: go to DONE.
- GAP:
  - serial_out=0, valid_out=0, busy=1 for exactly gap cycles, then SHIFT from bit 0.
  - pattern, len, and gap are NOT re-sampled; they stay as captured at start.
- DONE:
  - done=1 for one cycle; busy=0 in that same cycle; valid_out=0.
  - Next state IDLE. A start asserted during DONE is ignored.
- abort=1 in SHIFT, GAP, or DONE:
  - Next cycle is IDLE with serial_out=0, valid_out=0, busy=0.
  - No done pulse is generated.
  - abort in IDLE has no effect. abort has priority over start when both are asserted in IDLE.
- start while busy is ignored; no queuing.
- Async reset mid-frame: outputs go to their reset values immediately; no partial frame resumes after release.
- Counter arithmetic is unsigned. The bit counter must not wrap past len-1.

Optional Feature:
- Macro: PATTERN_TX_PARITY_EN.
- Defined: after the len data bits, one extra cycle with valid_out=1 carries even parity (XOR of the transmitted len bits). Frame length becomes len+1. GAP/DONE decisions are taken after the parity bit.
- Undefined: no parity cycle; frame is exactly len bits; no parity logic is synthesized.

Test Plan:
- Reset mid-frame: assert rst during the 4th bit of an 8-bit frame -> serial_out, valid_out, busy, and done are 0 immediately; after release, no output until a new start.
- Single frame (PAT_W=8, MSB_FIRST=1): pattern=8'b1011_0010, len=8, repeat_en=0, start at edge k -> serial_out=1,0,1,1,0,0,1,0 at cycles k+1..k+8 with valid_out=1; done=1 and busy=0 at k+9.
- Short frame and clamping: pattern=8'hA5, len=3 -> bits 1,0,1 then done. len=0 -> full 8 bits 1,0,1,0,0,1,0,1.
- Repeat: pattern=8'hF0, len=4, gap=2, repeat_en=1 -> 1,1,1,1, two invalid cycles, 1,1,1,1, ... Drop repeat_en during the 2nd frame -> that frame completes, then done pulse. With gap=0 -> 8 consecutive valid bits.
- Abort and ignored start: start a frame; pulse start again at bit 2 -> no effect on the frame. Assert abort at bit 5 -> IDLE next cycle, valid_out=0, no done pulse.
- With PATTERN_TX_PARITY_EN: pattern=8'b0000_0111, len=3 -> 1,1,1 then parity bit 1, valid_out=1 for 4 cycles, then done.
